iob_axis_tx_serializer: RTL and testbench

AXI-Stream transmitter: the output side of the stream subsystem, the counterpart of the stream-input receiver. It accepts DATA_W-bit words from the CPU/system side into an internal FIFO, serializes each word into R = DATA_W/TDATA_W beats (LSB slice first), and asserts TLAST on the programmed beat of each packet. After TLAST it discards any unsent slices of the current word, which strips the receiver-side padding.

---
 rtl/iob_axis_tx_serializer_pkg.sv | 28 ++
 rtl/iob_axis_tx_fifo.sv | 61 ++++++
 rtl/iob_axis_tx_serializer.sv | 180 ++++++++++++++++++
 tb/tb_iob_axis_tx_serializer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_axis_tx_serializer_pkg.sv
// Shared definitions for the AXI-Stream transmit serializer.
//  - state_t      : serializer FSM encoding (IDLE=0, SEND=1, STARVE=2)
//  - R / R_W      : beats per word and beat-index width for the default widths
//  - beat_ratio() : beats per word for any DATA_W/TDATA_W pair
//  - idx_width()  : beat-index width, never narrower than one bit
package iob_axis_tx_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_STARVE = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TDATA_W = 8;
  localparam int R           = DEF_DATA_W / DEF_TDATA_W;
  localparam int R_W         = $clog2(R);

  function automatic int beat_ratio(input int data_w, input int tdata_w);
    return data_w / tdata_w;
  endfunction

  // A ratio of 1 still needs a one-bit index so the vectors stay legal.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/iob_axis_tx_fifo.sv
// Synchronous first-word-fall-through word FIFO.
// Ports:
//  clk_i, cke_i, arst_n_i, rst_i : clock, clock enable, async reset (low), soft reset
//  push_i / data_i               : write request and word; ignored when full
//  pop_i / data_o                : read request and head word (valid when not empty)
//  level_o, empty_o, full_o      : occupancy status
// A written word becomes visible only after the write edge (no bypass).
module iob_axis_tx_fifo #(
  parameter int W      = 32,
  parameter int ADDR_W = 4
) (
  input  logic            clk_i,
  input  logic            cke_i,
  input  logic            arst_n_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [W-1:0]    data_i,
  input  logic            pop_i,
  output logic [W-1:0]    data_o,
  output logic [ADDR_W:0] level_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [W-1:0]    mem [2**ADDR_W];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level_o = wr_ptr - rd_ptr;
  assign empty_o = (level_o == '0);
  assign full_o  = (level_o == DEPTH);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (cke_i && !rst_i && do_push) mem[wr_ptr[ADDR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/iob_axis_tx_serializer.sv
// AXI-Stream transmitter: buffers DATA_W-bit words, emits each as
// DATA_W/TDATA_W beats (least significant slice first), and raises TLAST on
// the programmed beat of a packet. Slices left in a word after TLAST are dropped.
// Ports:
//  clk_i, arst_n_i, cke_i, rst_i    : clock, async reset (low), clock enable, soft reset
//  enable_i, nbeats_i               : packet start permission and length (beats)
//  in_valid_i/in_ready_o/in_data_i  : word write handshake
//  axis_t*                          : AXI-Stream master
//  fifo_level_o/empty_o/full_o      : word FIFO status (excludes word being sent)
//  busy_o, done_o, sent_beats_o     : packet status
//  dbg_state_o                      : current FSM state
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high; valid never waits for ready, and once raised, valid/data/last hold
// until that transfer.
module iob_axis_tx_serializer
  import iob_axis_tx_serializer_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TDATA_W     = DEF_TDATA_W,
  parameter int FIFO_ADDR_W = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 cke_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [CNT_W-1:0]     nbeats_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_W-1:0]    in_data_i,
  output logic                 axis_tvalid_o,
  input  logic                 axis_tready_i,
  output logic [TDATA_W-1:0]   axis_tdata_o,
  output logic                 axis_tlast_o,
  output logic [FIFO_ADDR_W:0] fifo_level_o,
  output logic                 fifo_empty_o,
  output logic                 fifo_full_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     sent_beats_o,
  output state_t               dbg_state_o
);

  localparam int              RATIO    = beat_ratio(DATA_W, TDATA_W);
  localparam int              IDX_W    = idx_width(RATIO);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  shreg;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   nbeats_q;
  logic [CNT_W-1:0]   sent_q;
  logic               done_q;

  logic [DATA_W-1:0]  fifo_data;
  logic               fifo_push;
  logic               fifo_pop;
  logic               start;
  logic               load;
  logic               shift;
  logic               hs;
  logic               last_beat;

  // FIFO
  assign in_ready_o = ~fifo_full_o;
  assign fifo_push  = in_valid_i & in_ready_o;

  iob_axis_tx_fifo #(
    .W      (DATA_W),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .cke_i    (cke_i),
    .arst_n_i (arst_n_i),
    .rst_i    (rst_i),
    .push_i   (fifo_push),
    .data_i   (in_data_i),
    .pop_i    (fifo_pop),
    .data_o   (fifo_data),
    .level_o  (fifo_level_o),
    .empty_o  (fifo_empty_o),
    .full_o   (fifo_full_o)
  );

  // Outputs derive from registers only, so tvalid cannot depend on tready.
  assign axis_tvalid_o = (state == ST_SEND);
  assign axis_tdata_o  = shreg[TDATA_W-1:0];
  assign axis_tlast_o  = (state == ST_SEND) && (sent_q == nbeats_q - CNT_W'(1));
  assign busy_o        = (state != ST_IDLE);
  assign done_o        = done_q;
  assign sent_beats_o  = sent_q;
  assign dbg_state_o   = state;

  assign hs        = axis_tvalid_o & axis_tready_i;
  assign last_beat = hs & axis_tlast_o;

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    start     = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable_i && (nbeats_i != '0) && !fifo_empty_o) begin
          fifo_pop  = 1'b1;
          start     = 1'b1;
          load      = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (last_beat) begin
            // Remaining slices of this word are discarded.
            state_nxt = ST_IDLE;
          end else if (idx == IDX_LAST) begin
            if (!fifo_empty_o) begin
              // Reload in the same cycle so the stream has no bubble.
              fifo_pop = 1'b1;
              load     = 1'b1;
            end else begin
              state_nxt = ST_STARVE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      ST_STARVE: begin
        if (!fifo_empty_o) begin
          fifo_pop  = 1'b1;
          load      = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      idx      <= '0;
      nbeats_q <= '0;
      sent_q   <= '0;
      done_q   <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        state    <= ST_IDLE;
        shreg    <= '0;
        idx      <= '0;
        nbeats_q <= '0;
        sent_q   <= '0;
        done_q   <= 1'b0;
      end else begin
        state  <= state_nxt;
        done_q <= last_beat;
        if (load) begin
          shreg <= fifo_data;
          idx   <= '0;
        end else if (shift) begin
          shreg <= shreg >> TDATA_W;
          idx   <= idx + IDX_W'(1);
        end
        if (start) begin
          nbeats_q <= nbeats_i;
          sent_q   <= '0;
        end else if (hs) begin
          sent_q <= sent_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_axis_tx_serializer.sv
module tb_iob_axis_tx_serializer;
  import iob_axis_tx_serializer_pkg::*;

  localparam int DW = 32;
  localparam int TW = 8;
  localparam int RR = DW / TW;
  localparam int AW = 4;
  localparam int CW = 16;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n = 1'b0;
  logic          cke = 1'b1;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] nbeats = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          tready = 1'b0;
  logic          in_ready;
  logic          tvalid;
  logic [TW-1:0] tdata;
  logic          tlast;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent;
  state_t        dbg_state;

  iob_axis_tx_serializer #(
    .DATA_W(DW), .TDATA_W(TW), .FIFO_ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .rst_i(rst),
    .enable_i(enable), .nbeats_i(nbeats),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .axis_tvalid_o(tvalid), .axis_tready_i(tready),
    .axis_tdata_o(tdata), .axis_tlast_o(tlast),
    .fifo_level_o(level), .fifo_empty_o(empty), .fifo_full_o(full),
    .busy_o(busy), .done_o(done), .sent_beats_o(sent),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: planned words and the beats they must produce.
  logic [DW-1:0] wq[$];
  logic [TW:0]   exp_q[$];   // {tlast, tdata}

  // A packet of nb beats walks the word queue slice by slice (LSB first);
  // whatever is left of the final word is simply never emitted.
  task automatic add_packet(input int nb);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < nb; k++) begin
      if (k % RR == 0) begin
        if (wq.size() == 0) begin
          $display("FAIL model_words: need word for beat %0d, have 0 expected >0", k);
          n_fail++;
          return;
        end
        w = wq.pop_front();
      end
      exp_q.push_back({(k == nb - 1), w[TW*(k%RR) +: TW]});
    end
  endtask

  // Monitor: beat scoreboard, stall stability, pulse counting, gap timing.
  int          cyc = 0;
  int          done_cnt = 0;
  logic        mon_off = 1'b0;
  logic        gap_check = 1'b0;
  logic        prev_stall = 1'b0;
  logic [TW:0] prev_beat = '0;
  logic        prev_was_last = 1'b0;
  int          prev_hs_cyc = 0;
  logic        rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready) tready = ($urandom_range(3) == 0);
  end

  always @(negedge clk) begin
    logic [TW:0] e;
    if (done) done_cnt++;
    if (!mon_off && prev_stall) begin
      n_checks++;
      if (tvalid !== 1'b1 || {tlast, tdata} !== prev_beat) begin
        $display("FAIL stall_hold: got v=%b beat=%h expected v=1 beat=%h", tvalid, {tlast, tdata}, prev_beat);
        n_fail++;
      end
    end
    prev_stall = !mon_off && tvalid && !tready;
    prev_beat  = {tlast, tdata};
    if (tvalid && tready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat_unexpected: got %h expected none", {tlast, tdata});
        n_fail++;
      end else begin
        e = exp_q.pop_front();
        if ({tlast, tdata} !== e) begin
          $display("FAIL beat: got last=%b data=%h expected last=%b data=%h", tlast, tdata, e[TW], e[TW-1:0]);
          n_fail++;
        end
      end
      if (gap_check && prev_was_last) begin
        n_checks++;
        if (cyc - prev_hs_cyc != 2) begin
          $display("FAIL packet_gap: got %0d cycles expected 2", cyc - prev_hs_cyc);
          n_fail++;
        end
      end
      prev_was_last = tlast;
      prev_hs_cyc   = cyc;
    end
  end

  // Driver tasks; all drive at posedge+1 and return aligned the same way.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    int t;
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    while (!in_ready && t < 3000) begin
      step(1);
      t++;
    end
    if (!in_ready) begin
      $display("FAIL push_timeout: got in_ready=0 expected 1");
      n_fail++;
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < budget) begin
      step(1);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy) begin
      $display("FAIL drain_timeout: got %0d beats pending busy=%b expected 0 and 0", exp_q.size(), busy);
      n_fail++;
      exp_q.delete();
    end
    step(2);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      $display("FAIL %s: got %0h expected %0h", name, got, want);
      n_fail++;
    end
  endtask

  // Tests
  task automatic test_reset();
    check_val("rst_tvalid", 32'(tvalid), 0);
    check_val("rst_in_ready", 32'(in_ready), 1);
    check_val("rst_empty", 32'(empty), 1);
    check_val("rst_full", 32'(full), 0);
    check_val("rst_level", 32'(level), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_sent", 32'(sent), 0);
    check_val("rst_tlast", 32'(tlast), 0);
    check_val("rst_tdata", 32'(tdata), 0);
    arst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single();
    int d0;
    d0 = done_cnt;
    nbeats = 4; enable = 1'b1; tready = 1'b1;
    wq.push_back(32'h44332211);
    add_packet(4);
    push_word(32'h44332211);
    check_val("lat_t0_tvalid", 32'(tvalid), 0);
    step(1);
    check_val("lat_t1_tvalid", 32'(tvalid), 1);
    check_val("first_tdata", 32'(tdata), 32'h11);
    wait_drain(100);
    check_val("single_done_cnt", 32'(done_cnt - d0), 1);
    check_val("single_sent", 32'(sent), 4);
  endtask

  task automatic test_drop();
    nbeats = 6;
    wq.push_back(32'h44332211);
    wq.push_back(32'h88776655);
    add_packet(6);
    push_word(32'h44332211);
    push_word(32'h88776655);
    wait_drain(100);
    check_val("drop_sent", 32'(sent), 6);
    check_val("drop_empty", 32'(empty), 1);
    check_val("drop_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic test_random_stall();
    logic [DW-1:0] w[8];
    int d0;
    d0 = done_cnt;
    nbeats = 32;
    for (int i = 0; i < 8; i++) begin
      w[i] = $urandom;
      wq.push_back(w[i]);
    end
    add_packet(32);
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(w[i]);
    wait_drain(2000);
    rand_ready = 1'b0;
    tready = 1'b1;
    check_val("rand_sent", 32'(sent), 32);
    check_val("rand_done_cnt", 32'(done_cnt - d0), 1);
  endtask

  task automatic test_full();
    logic [DW-1:0] w;
    nbeats = 68; tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      wq.push_back(w);
      push_word(w);
    end
    check_val("full16_level", 32'(level), 15);
    check_val("full16_in_ready", 32'(in_ready), 1);
    w = $urandom;
    wq.push_back(w);
    push_word(w);
    check_val("full17_level", 32'(level), 16);
    check_val("full17_full", 32'(full), 1);
    check_val("full17_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = $urandom;
    step(3);
    in_valid = 1'b0;
    check_val("refused_level", 32'(level), 16);
    add_packet(68);
    tready = 1'b1;
    wait_drain(500);
    check_val("full_drained_empty", 32'(empty), 1);
  endtask

  task automatic test_starve();
    logic [DW-1:0] w1, w2;
    int t;
    w1 = $urandom; w2 = $urandom;
    nbeats = 8; enable = 1'b1; tready = 1'b1;
    wq.push_back(w1); wq.push_back(w2);
    add_packet(8);
    push_word(w1);
    t = 0;
    while (exp_q.size() > 4 && t < 100) begin
      step(1);
      t++;
    end
    step(5);
    // Mid-packet changes that must not affect the running packet.
    enable = 1'b0;
    nbeats = 3;
    check_val("starve_tvalid", 32'(tvalid), 0);
    check_val("starve_state", 32'(dbg_state), 32'(ST_STARVE));
    check_val("starve_pending", 32'(exp_q.size()), 4);
    push_word(w2);
    wait_drain(100);
    check_val("starve_sent", 32'(sent), 8);
    enable = 1'b1;
  endtask

  task automatic test_soft_reset();
    int t;
    nbeats = 8; tready = 1'b0;
    wq.push_back(32'hA3A2A1A0); wq.push_back(32'hB3B2B1B0);
    add_packet(8);
    push_word(32'hA3A2A1A0);
    push_word(32'hB3B2B1B0);
    t = 0;
    while (!tvalid && t < 50) begin
      step(1);
      t++;
    end
    tready = 1'b1;
    step(2);
    tready = 1'b0;
    mon_off = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_val("srst_pending", 32'(exp_q.size()), 6);
    check_val("srst_tvalid", 32'(tvalid), 0);
    check_val("srst_empty", 32'(empty), 1);
    check_val("srst_sent", 32'(sent), 0);
    check_val("srst_busy", 32'(busy), 0);
    exp_q.delete();
    step(2);
    mon_off = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_gating();
    logic [DW-1:0] w;
    w = $urandom;
    nbeats = 0; enable = 1'b1; tready = 1'b1;
    push_word(w);
    step(10);
    check_val("nb0_busy", 32'(busy), 0);
    check_val("nb0_level", 32'(level), 1);
    nbeats = 4; enable = 1'b0;
    step(10);
    check_val("en0_busy", 32'(busy), 0);
    check_val("en0_level", 32'(level), 1);
    wq.push_back(w);
    add_packet(4);
    enable = 1'b1;
    wait_drain(100);
    check_val("gate_sent", 32'(sent), 4);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[3];
    int d0;
    d0 = done_cnt;
    nbeats = 4; enable = 1'b1; tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      wq.push_back(w[i]);
      add_packet(4);
    end
    prev_was_last = 1'b0;
    gap_check = 1'b1;
    for (int i = 0; i < 3; i++) push_word(w[i]);
    wait_drain(200);
    gap_check = 1'b0;
    check_val("b2b_done_cnt", 32'(done_cnt - d0), 3);
  endtask

  initial begin
    step(3);
    test_reset();
    test_single();
    test_drop();
    test_random_stall();
    test_full();
    test_starve();
    test_soft_reset();
    test_gating();
    test_back_to_back();
    check_val("final_exp_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
